// File: rtl/fifo_rd_burst_drain_pkg.sv
// Shared types and sizing helpers for the read-side burst drain.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } drain_state_e;

    localparam int DEF_BURST_LEN = 16;
    localparam int BEAT_W        = $clog2(DEF_BURST_LEN);

    // Beat index width for an arbitrary burst length (>= 2).
    function automatic int beat_w_f(input int burst_len);
        return (burst_len <= 2) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/fifo_rd_burst_drain_if.sv
// FIFO read port plus the outgoing valid/ready stream.
// master = the drain block, slave = FIFO/stream environment.
interface fifo_rd_burst_drain_if #(
    parameter int DATA_SIZE = 12
);
    logic                 rinc;
    logic                 rEmpty;
    logic [DATA_SIZE-1:0] rData;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output rinc,
        input  rEmpty,
        input  rData,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rinc,
        output rEmpty,
        output rData,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo_rd_burst_drain_skid_buf2.sv
// Two-entry prefetch buffer between the FIFO read port and the stream.
// Push and pop in the same cycle leave occupancy unchanged.
module skid_buf2 #(
    parameter int DATA_SIZE = 12
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 push_i,
    input  logic [DATA_SIZE-1:0] din_i,
    input  logic                 pop_i,
    output logic [DATA_SIZE-1:0] dout_o,
    output logic [1:0]           occ_o
);

    logic [DATA_SIZE-1:0] mem_q [2];
    logic                 wp_q, rp_q;
    logic [1:0]           occ_q, occ_d;
    logic                 push_ok, pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push_i && (occ_q != 2'd2);
    assign pop_ok  = pop_i  && (occ_q != 2'd0);
    assign dout_o  = mem_q[rp_q];
    assign occ_o   = occ_q;

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        occ_d = occ_q;
        if (push_ok && !pop_ok)
            occ_d = occ_q + 2'd1;
        else if (!push_ok && pop_ok)
            occ_d = occ_q - 2'd1;
    end

    // Storage, pointers and occupancy; reset discards buffered words.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= ~wp_q;
            end
            if (pop_ok)
                rp_q <= ~rp_q;
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_rd_burst_drain.sv
// Read-domain FIFO consumer: prefetches through a 2-entry buffer, frames
// the stream into fixed-length bursts and only stops on a burst boundary.
import fifo_drain_pkg::*;

module fifo_rd_burst_drain #(
    parameter int DATA_SIZE = 12,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                        rclk,
    input  logic                        rrst,
    input  logic                        en,
    output logic [CNT_W-1:0]            burst_cnt,
    output logic                        busy,
    fifo_rd_burst_drain_if.master       bus
);

    localparam int BW = beat_w_f(BURST_LEN);

    drain_state_e         state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [CNT_W-1:0]     bcnt_q, bcnt_d;

    logic [1:0]           occ;
    logic [DATA_SIZE-1:0] head;
    logic                 pop_allow, rinc, fire, out_valid, last_beat;
    logic                 at_boundary, burst_full;
    logic [BW:0]          pops_pending;

    // Words already committed to the current burst: buffered + delivered.
    assign pops_pending = (BW+1)'(occ) + (BW+1)'(beat_q);
    assign burst_full   = pops_pending >= (BW+1)'(BURST_LEN);
    assign at_boundary  = (beat_q == '0) && (occ == 2'd0);

    // Pop depends only on registered state and rEmpty, never on out_ready.
    assign rinc      = !bus.rEmpty && (occ != 2'd2) && pop_allow;
    assign out_valid = (occ != 2'd0);
    assign last_beat = (beat_q == BW'(BURST_LEN - 1));
    assign fire      = out_valid && bus.out_ready;

    assign bus.rinc      = rinc;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head;
    assign bus.out_last  = out_valid && last_beat;
    assign burst_cnt     = bcnt_q;
    assign busy          = (state_q != IDLE) || (occ != 2'd0);

    skid_buf2 #(.DATA_SIZE(DATA_SIZE)) u_buf (
        .rclk   (rclk),
        .rrst   (rrst),
        .push_i (rinc),
        .din_i  (bus.rData),
        .pop_i  (fire),
        .dout_o (head),
        .occ_o  (occ)
    );

    // Enable/stop FSM: next state and pop permission.
    always_comb begin
        state_d   = state_q;
        pop_allow = 1'b0;
        case (state_q)
            IDLE: begin
                if (en)
                    state_d = RUN;
            end
            RUN: begin
                pop_allow = 1'b1;
                if (!en)
                    state_d = STOP;
            end
            STOP: begin
                // Only fetch what the open burst still needs.
                pop_allow = !at_boundary && !burst_full;
                if (en)
                    state_d = RUN;
                else if (at_boundary)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat index and completed-burst counter advance on each fire.
    always_comb begin
        beat_d = beat_q;
        bcnt_d = bcnt_q;
        if (fire) begin
            if (last_beat) begin
                beat_d = '0;
                bcnt_d = bcnt_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // State, beat and burst registers.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst_drain.sv
// Directed + randomized bench for fifo_rd_burst_drain with a queue-based
// FIFO model and an in-order stream scoreboard.
module tb_fifo_rd_burst_drain;
    import fifo_drain_pkg::*;

    localparam int DS = 12;
    localparam int BL = 16;
    localparam int CW = 2;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          en;
    logic [CW-1:0] burst_cnt;
    logic          busy;

    fifo_rd_burst_drain_if #(.DATA_SIZE(DS)) ifc ();

    fifo_rd_burst_drain #(.DATA_SIZE(DS), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .en        (en),
        .burst_cnt (burst_cnt),
        .busy      (busy),
        .bus       (ifc)
    );

    always #5 rclk = ~rclk;

    int            checks = 0;
    int            errors = 0;
    logic [DS-1:0] fifo_q[$];
    logic [DS-1:0] exp_q[$];
    int            beats, bursts, pops, cyc, first_fire, last_fire;
    bit            rnd_ready, stall_q;
    logic [DS-1:0] stall_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model pop side: a popped word becomes the next expected beat.
    always @(posedge rclk) begin
        cyc++;
        if (!rrst && ifc.rinc && fifo_q.size() > 0) begin
            exp_q.push_back(fifo_q.pop_front());
            pops++;
        end
    end

    // Stream monitor, then refresh the FIFO model outputs.
    always @(negedge rclk) begin
        if (!rrst) begin
            if (ifc.rinc)
                chk("rinc_on_empty", 32'(ifc.rEmpty), 32'd0);
            chk("occ_bound", 32'(exp_q.size() <= 2), 32'd1);
            chk("out_valid", 32'(ifc.out_valid), 32'(exp_q.size() > 0));
            chk("out_last", 32'(ifc.out_last), 32'(exp_q.size() > 0 && (beats % BL) == BL - 1));
            chk("burst_cnt", 32'(burst_cnt), 32'(bursts % (1 << CW)));
            if (stall_q) begin
                chk("stall_valid", 32'(ifc.out_valid), 32'd1);
                chk("stall_data", 32'(ifc.out_data), 32'(stall_data));
            end
            stall_q    = ifc.out_valid && !ifc.out_ready;
            stall_data = ifc.out_data;
            if (ifc.out_valid && ifc.out_ready && exp_q.size() > 0) begin
                chk("data", 32'(ifc.out_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                if ((beats % BL) == BL - 1)
                    bursts++;
                beats++;
                if (first_fire < 0)
                    first_fire = cyc;
                last_fire = cyc;
            end
        end else begin
            stall_q = 1'b0;
        end
        ifc.rEmpty = (fifo_q.size() == 0);
        ifc.rData  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    task automatic step();
        @(posedge rclk);
        #1;
        if (rnd_ready)
            ifc.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        rrst          = 1'b1;
        en            = 1'b0;
        ifc.out_ready = 1'b0;
        rnd_ready     = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        beats      = 0;
        bursts     = 0;
        pops       = 0;
        first_fire = -1;
        last_fire  = -1;
        stall_q    = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_rinc", 32'(ifc.rinc), 32'd0);
        chk("rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_last", 32'(ifc.out_last), 32'd0);
        chk("rst_data", 32'(ifc.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcnt", 32'(burst_cnt), 32'd0);
        rrst = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && beats < n; i++)
            step();
        chk(tag, 32'(beats), 32'(n));
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++)
            fifo_q.push_back(DS'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_b, k;
        int wrap_exp [5];
        wrap_exp = '{1, 2, 3, 0, 1};
        ifc.rEmpty    = 1'b1;
        ifc.rData     = '0;
        ifc.out_ready = 1'b0;
        rrst          = 1'b1;
        en            = 1'b0;
        cyc           = 0;

        // 1: 32 preloaded words, ready always high, back-to-back delivery.
        do_reset();
        for (int i = 1; i <= 32; i++)
            fifo_q.push_back(DS'(i));
        ifc.out_ready = 1'b1;
        en            = 1'b1;
        wait_beats(32, 200, "s1_beats");
        chk("s1_bcnt", 32'(burst_cnt), 32'd2);
        chk("s1_spacing", 32'(last_fire - first_fire), 32'd31);
        en = 1'b0;
        repeat (4) step();
        chk("s1_idle", 32'(busy), 32'd0);

        // 2: backpressure with 5 words: two pops then hold.
        do_reset();
        for (int i = 1; i <= 5; i++)
            fifo_q.push_back(DS'(i));
        en = 1'b1;
        repeat (10) step();
        chk("s2_pops", 32'(pops), 32'd2);
        chk("s2_rinc", 32'(ifc.rinc), 32'd0);
        chk("s2_hold_data", 32'(ifc.out_data), 32'h001);
        chk("s2_hold_valid", 32'(ifc.out_valid), 32'd1);
        ifc.out_ready = 1'b1;
        wait_beats(5, 50, "s2_beats");
        chk("s2_fifo_left", 32'(fifo_q.size()), 32'd0);

        // 3: stop requested after the 3rd beat; burst must complete.
        do_reset();
        push_rand(40);
        rnd_ready     = 1'b1;
        ifc.out_ready = 1'b1;
        en            = 1'b1;
        wait_beats(3, 100, "s3_beat3");
        en = 1'b0;
        for (int i = 0; i < 400 && busy; i++)
            step();
        chk("s3_busy", 32'(busy), 32'd0);
        chk("s3_beats", 32'(beats), 32'd16);
        chk("s3_pops", 32'(pops), 32'd16);
        chk("s3_fifo_left", 32'(fifo_q.size()), 32'd24);
        chk("s3_bcnt", 32'(burst_cnt), 32'd1);

        // 4: FIFO runs dry mid-burst, burst resumes when data returns.
        do_reset();
        push_rand(10);
        ifc.out_ready = 1'b1;
        en            = 1'b1;
        wait_beats(10, 60, "s4_beats10");
        for (int i = 0; i < 20; i++) begin
            step();
            chk("s4_gap_valid", 32'(ifc.out_valid), 32'd0);
        end
        push_rand(6);
        wait_beats(16, 60, "s4_beats16");
        chk("s4_bcnt", 32'(burst_cnt), 32'd1);

        // 5: async reset with a full buffer at beat index 7.
        do_reset();
        push_rand(20);
        ifc.out_ready = 1'b1;
        en            = 1'b1;
        wait_beats(7, 60, "s5_beats7");
        ifc.out_ready = 1'b0;
        repeat (4) step();
        chk("s5_full_valid", 32'(ifc.out_valid), 32'd1);
        chk("s5_full_rinc", 32'(ifc.rinc), 32'd0);
        chk("s5_full_pops", 32'(pops), 32'd9);
        @(negedge rclk);
        #2;
        rrst = 1'b1;
        #1;
        chk("s5_async_valid", 32'(ifc.out_valid), 32'd0);
        chk("s5_async_data", 32'(ifc.out_data), 32'd0);
        chk("s5_async_busy", 32'(busy), 32'd0);
        chk("s5_async_rinc", 32'(ifc.rinc), 32'd0);
        do_reset();
        push_rand(16);
        ifc.out_ready = 1'b1;
        en            = 1'b1;
        wait_beats(16, 80, "s5_beats16");
        chk("s5_bcnt", 32'(burst_cnt), 32'd1);

        // 6: burst counter wrap with a 2-bit counter, random backpressure.
        do_reset();
        push_rand(80);
        rnd_ready     = 1'b1;
        ifc.out_ready = 1'b1;
        en            = 1'b1;
        prev_b        = 0;
        k             = 0;
        for (int i = 0; i < 800 && bursts < 5; i++) begin
            step();
            if (bursts != prev_b && k < 5) begin
                chk("s6_wrap_seq", 32'(burst_cnt), 32'(wrap_exp[k]));
                k++;
                prev_b = bursts;
            end
        end
        chk("s6_bursts", 32'(k), 32'd5);
        en = 1'b0;
        repeat (4) step();
        chk("s6_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
